// File: rtl/pwm_io_pkg.sv
// Shared types and constants for the PWM capture block.
// Holds the capture FSM state type and the default counter width.
package pwm_io_pkg;

    localparam int unsigned PWM_CNT_WIDTH_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } pwm_state_e;

endpackage

// File: rtl/pwm_capture_if.sv
// Measurement result/handshake bundle of pwm_capture.
// The master side produces measurements; the slave side consumes them.
interface pwm_capture_if
    import pwm_io_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = PWM_CNT_WIDTH_DEFAULT
) ();

    logic                 ready;
    logic                 valid;
    logic [CNT_WIDTH-1:0] high_cnt;
    logic [CNT_WIDTH-1:0] period_cnt;
    logic                 overrun;
    logic                 timeout;

    modport master (
        input  ready,
        output valid, high_cnt, period_cnt, overrun, timeout
    );

    modport slave (
        output ready,
        input  valid, high_cnt, period_cnt, overrun, timeout
    );

endinterface

// File: rtl/pwm_edge_detect.sv
// Two-flop synchronizer, optional glitch filter and rise/fall detection.
// Glitch filter is built only when PWM_CAPTURE_FILTER_EN is defined.
module pwm_edge_detect
    import pwm_io_pkg::*;
#(
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic CLK,
    input  logic _RST,
    input  logic pwm_i,
    output logic rise_o,
    output logic fall_o
);

    logic s1_q;
    logic s2_q;
    logic s3_q;
    logic lvl;

    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= pwm_i;
            s2_q <= s1_q;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    localparam int unsigned FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic           filt_q;
    logic           filt_d;
    logic [FCW-1:0] fcnt_q;
    logic [FCW-1:0] fcnt_d;

    // Counts consecutive cycles the synchronized level differs from the
    // filtered level; any return to the filtered level restarts the count.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (s2_q != filt_q) begin
            if (fcnt_q == FCW'(FILTER_LEN - 1)) begin
                filt_d = s2_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            filt_q <= 1'b0;
            fcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    assign lvl = filt_q;
`else
    logic unused_filter_len;
    assign unused_filter_len = ^FILTER_LEN;
    assign lvl = s2_q;
`endif

    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            s3_q <= 1'b0;
        end else begin
            s3_q <= lvl;
        end
    end

    assign rise_o = lvl & ~s3_q;
    assign fall_o = ~lvl & s3_q;

endmodule

// File: rtl/pwm_capture.sv
// PWM high-time / period capture with valid/ready result handshake.
// Optional input glitch filter enabled by defining PWM_CAPTURE_FILTER_EN.
module pwm_capture
    import pwm_io_pkg::*;
#(
    parameter int unsigned CNT_WIDTH  = PWM_CNT_WIDTH_DEFAULT,
    parameter int unsigned FILTER_LEN = 4
) (
    input  logic                 CLK,
    input  logic                 _RST,
    input  logic                 PWM_IN,
    input  logic                 CLR,
    input  logic                 READY,
    output logic                 VALID,
    output logic [CNT_WIDTH-1:0] HIGH_CNT,
    output logic [CNT_WIDTH-1:0] PERIOD_CNT,
    output logic                 OVERRUN,
    output logic                 TIMEOUT
);

    logic rise;
    logic fall;

    pwm_edge_detect #(
        .FILTER_LEN (FILTER_LEN)
    ) u_edge (
        .CLK    (CLK),
        ._RST   (_RST),
        .pwm_i  (PWM_IN),
        .rise_o (rise),
        .fall_o (fall)
    );

    pwm_state_e           state_q, state_d;
    logic [CNT_WIDTH-1:0] p_q, p_d;
    logic [CNT_WIDTH-1:0] h_q, h_d;
    logic [CNT_WIDTH-1:0] hcnt_q, hcnt_d;
    logic [CNT_WIDTH-1:0] pcnt_q, pcnt_d;
    logic                 valid_q, valid_d;
    logic                 ovr_q, ovr_d;
    logic                 to_q, to_d;
    logic                 done;

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        h_d     = h_q;
        hcnt_d  = hcnt_q;
        pcnt_d  = pcnt_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        to_d    = to_q;
        done    = 1'b0;

        if (CLR) begin
            state_d = IDLE;
            p_d     = '0;
            h_d     = '0;
            hcnt_d  = '0;
            pcnt_d  = '0;
            valid_d = 1'b0;
            ovr_d   = 1'b0;
            to_d    = 1'b0;
        end else begin
            if (rise) begin
                to_d = 1'b0;
            end
            // Saturation outranks any edge seen on the same cycle.
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        state_d = HIGH;
                        p_d     = CNT_WIDTH'(1);
                    end
                end
                HIGH: begin
                    if (p_q == '1) begin
                        state_d = IDLE;
                        to_d    = 1'b1;
                    end else if (rise) begin
                        p_d = CNT_WIDTH'(1);
                    end else begin
                        p_d = p_q + 1'b1;
                        if (fall) begin
                            state_d = LOW;
                            h_d     = p_q;
                        end
                    end
                end
                LOW: begin
                    if (p_q == '1) begin
                        state_d = IDLE;
                        to_d    = 1'b1;
                    end else if (rise) begin
                        state_d = HIGH;
                        p_d     = CNT_WIDTH'(1);
                        done    = 1'b1;
                    end else begin
                        p_d = p_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase

            if (done) begin
                if (!valid_q || READY) begin
                    valid_d = 1'b1;
                    hcnt_d  = h_q;
                    pcnt_d  = p_q;
                end else begin
                    ovr_d = 1'b1;
                end
            end else if (valid_q && READY) begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge CLK or negedge _RST) begin
        if (!_RST) begin
            state_q <= IDLE;
            p_q     <= '0;
            h_q     <= '0;
            hcnt_q  <= '0;
            pcnt_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
            to_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            h_q     <= h_d;
            hcnt_q  <= hcnt_d;
            pcnt_q  <= pcnt_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
            to_q    <= to_d;
        end
    end

    assign VALID      = valid_q;
    assign HIGH_CNT   = hcnt_q;
    assign PERIOD_CNT = pcnt_q;
    assign OVERRUN    = ovr_q;
    assign TIMEOUT    = to_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: 16-bit and 8-bit instances share one stimulus and
// are checked every cycle against an edge-timestamp model of the capture.
module tb_pwm_capture;
    import pwm_io_pkg::*;

    localparam int unsigned FL = 4;
`ifdef PWM_CAPTURE_FILTER_EN
    localparam int LAT = 2 + FL;
`else
    localparam int LAT = 2;
`endif

    logic CLK = 1'b0;
    logic rst_n = 1'b0;
    logic pwm = 1'b0;
    logic clr = 1'b0;
    logic rdy = 1'b1;

    pwm_capture_if #(.CNT_WIDTH(16)) if16 ();
    pwm_capture_if #(.CNT_WIDTH(8))  if8 ();

    assign if16.ready = rdy;
    assign if8.ready  = rdy;

    pwm_capture #(.CNT_WIDTH(16), .FILTER_LEN(FL)) dut16 (
        .CLK(CLK), ._RST(rst_n), .PWM_IN(pwm), .CLR(clr), .READY(if16.ready),
        .VALID(if16.valid), .HIGH_CNT(if16.high_cnt), .PERIOD_CNT(if16.period_cnt),
        .OVERRUN(if16.overrun), .TIMEOUT(if16.timeout)
    );

    pwm_capture #(.CNT_WIDTH(8), .FILTER_LEN(FL)) dut8 (
        .CLK(CLK), ._RST(rst_n), .PWM_IN(pwm), .CLR(clr), .READY(if8.ready),
        .VALID(if8.valid), .HIGH_CNT(if8.high_cnt), .PERIOD_CNT(if8.period_cnt),
        .OVERRUN(if8.overrun), .TIMEOUT(if8.timeout)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int fails  = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            fails++;
            if (fails <= 25) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Model: measurements follow from timestamps of detected rise/fall edges.
    typedef struct {
        bit     armed, fell, valid, ovr, to;
        longint r, tf, hc, pc;
    } mdl_t;

    mdl_t   m[2];
    longint cyc = 0;
    bit     x1, x2;
`ifdef PWM_CAPTURE_FILTER_EN
    bit     f, fprev;
    bit     lh[FL];
`else
    bit     lprev;
`endif

    function automatic mdl_t step(input mdl_t mi, input bit ri, input bit fa,
                                  input bit cl, input bit rd, input longint e, input longint mx);
        mdl_t   mo;
        bit     done;
        longint mh, mp;
        mo = mi; done = 0; mh = 0; mp = 0;
        if (cl) begin
            mo = '{default: 0};
            return mo;
        end
        if (mo.armed && (e - mo.r) == mx) begin
            mo.armed = 0; mo.to = 1;
        end else if (ri) begin
            if (mo.armed && mo.fell) begin
                done = 1; mh = mo.tf - mo.r; mp = e - mo.r;
            end
            mo.armed = 1; mo.fell = 0; mo.r = e; mo.to = 0;
        end else if (fa && mo.armed && !mo.fell) begin
            mo.fell = 1; mo.tf = e;
        end
        if (done) begin
            if (!mo.valid || rd) begin
                mo.valid = 1; mo.hc = mh; mo.pc = mp;
            end else begin
                mo.ovr = 1;
            end
        end else if (mo.valid && rd) begin
            mo.valid = 0;
        end
        return mo;
    endfunction

    always @(posedge CLK or negedge rst_n) begin
        bit lvl, cur, prv, ri, fa, all;
        cyc++;
        if (!rst_n) begin
            m[0] = '{default: 0};
            m[1] = '{default: 0};
            x1 = 0; x2 = 0;
`ifdef PWM_CAPTURE_FILTER_EN
            f = 0; fprev = 0;
            foreach (lh[i]) lh[i] = 0;
`else
            lprev = 0;
`endif
        end else begin
            lvl = x2;
`ifdef PWM_CAPTURE_FILTER_EN
            cur = f; prv = fprev; fprev = f;
            for (int i = FL - 1; i > 0; i--) lh[i] = lh[i-1];
            lh[0] = lvl;
            all = 1;
            foreach (lh[i]) if (lh[i] != lvl) all = 0;
            if (all) f = lvl;
`else
            cur = lvl; prv = lprev; lprev = lvl; all = 0;
`endif
            ri = cur & ~prv;
            fa = ~cur & prv;
            m[0] = step(m[0], ri, fa, clr, rdy, cyc, 65535);
            m[1] = step(m[1], ri, fa, clr, rdy, cyc, 255);
            x2 = x1; x1 = pwm;
        end
    end

    always @(negedge CLK) begin
        chk("valid16",   longint'(if16.valid),      longint'(m[0].valid));
        chk("high16",    longint'(if16.high_cnt),   m[0].hc);
        chk("period16",  longint'(if16.period_cnt), m[0].pc);
        chk("overrun16", longint'(if16.overrun),    longint'(m[0].ovr));
        chk("timeout16", longint'(if16.timeout),    longint'(m[0].to));
        chk("valid8",    longint'(if8.valid),       longint'(m[1].valid));
        chk("high8",     longint'(if8.high_cnt),    m[1].hc);
        chk("period8",   longint'(if8.period_cnt),  m[1].pc);
        chk("overrun8",  longint'(if8.overrun),     longint'(m[1].ovr));
        chk("timeout8",  longint'(if8.timeout),     longint'(m[1].to));
    end

    // Monitor of VALID rising edges on the DUTs, for directed literal checks.
    int     nv[2], vc[2];
    longint fh[2], fp[2], lhc[2], lpc[2];
    bit     pv[2];

    always @(negedge CLK) begin
        if (if16.valid) vc[0]++;
        if (if8.valid)  vc[1]++;
        if (if16.valid && !pv[0]) begin
            nv[0]++; lhc[0] = if16.high_cnt; lpc[0] = if16.period_cnt;
            if (nv[0] == 1) begin fh[0] = lhc[0]; fp[0] = lpc[0]; end
        end
        if (if8.valid && !pv[1]) begin
            nv[1]++; lhc[1] = if8.high_cnt; lpc[1] = if8.period_cnt;
            if (nv[1] == 1) begin fh[1] = lhc[1]; fp[1] = lpc[1]; end
        end
        pv[0] = if16.valid;
        pv[1] = if8.valid;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic phase(input bit lv, input int n);
        pwm = lv;
        tick(n);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
    endtask

    task automatic mon_clear();
        foreach (nv[i]) begin
            nv[i] = 0; vc[i] = 0; fh[i] = 0; fp[i] = 0; lhc[i] = 0; lpc[i] = 0;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        int hi, lo;

        // Reset state
        tick(3);
        chk("rst_valid16", if16.valid, 0);
        chk("rst_high16", if16.high_cnt, 0);
        chk("rst_timeout8", if8.timeout, 0);
        rst_n = 1'b1;
        mon_clear();

        // 10 high / 30 low, READY held high
        phase(0, 5);
        repeat (3) begin phase(1, 10); phase(0, 30); end
        phase(1, 10); phase(0, 10);
        chk("t1_nvalid16", nv[0], 3);
        chk("t1_vcycles16", vc[0], 3);
        chk("t1_high16", lhc[0], 10);
        chk("t1_period16", lpc[0], 40);
        chk("t1_nvalid8", nv[1], 3);
        chk("t1_model_pc", m[0].pc, 40);

        // READY low across several 5/5 periods: hold first result, overrun
        do_clr();
        rdy = 1'b0;
        mon_clear();
        phase(0, 5);
        repeat (3) begin phase(1, 5); phase(0, 5); end
        phase(1, 5); phase(0, 5);
        chk("t2_valid16", if16.valid, 1);
        chk("t2_high16", if16.high_cnt, 5);
        chk("t2_period16", if16.period_cnt, 10);
        chk("t2_overrun16", if16.overrun, 1);
        rdy = 1'b1;
        tick(1);
        chk("t2_valid_drop16", if16.valid, 0);
        chk("t2_overrun_sticky16", if16.overrun, 1);
        do_clr();
        chk("t2_overrun_clr16", if16.overrun, 0);

        // Stuck high: 8-bit counter saturates
        mon_clear();
        phase(0, 5);
        phase(1, 300);
        chk("t3_timeout8", if8.timeout, 1);
        chk("t3_nvalid8", nv[1], 0);
        chk("t3_timeout16", if16.timeout, 0);
        chk("t3_model_to8", m[1].to, 1);
        phase(0, 5); phase(1, 8); phase(0, 5);
        chk("t3_timeout_clr8", if8.timeout, 0);

        // Short high glitch inside a low phase
        do_clr();
        mon_clear();
        phase(0, 10); phase(1, 8); phase(0, 8); phase(1, 2); phase(0, 10);
        phase(1, 8); phase(0, 10);
`ifdef PWM_CAPTURE_FILTER_EN
        chk("t4_nvalid16", nv[0], 1);
        chk("t4_high16", lhc[0], 8);
        chk("t4_period16", lpc[0], 28);
`else
        chk("t4_nvalid16", nv[0], 2);
        chk("t4_high16", lhc[0], 2);
        chk("t4_period16", lpc[0], 12);
`endif

        // Reset pulse during a high phase, released while low
        phase(0, 5); phase(1, 4);
        rst_n = 1'b0;
        tick(1);
        chk("t5_rst_high16", if16.high_cnt, 0);
        chk("t5_rst_period8", if8.period_cnt, 0);
        phase(1, 3); phase(0, 3);
        rst_n = 1'b1;
        mon_clear();
        phase(0, 5);
        repeat (2) begin phase(1, 8); phase(0, 8); end
        phase(1, 8); phase(0, 8);
        chk("t5_nvalid16", nv[0], 2);
        chk("t5_first_high16", fh[0], 8);
        chk("t5_first_period16", fp[0], 16);

        // CLR on the same cycle as a detected rise
        do_clr();
        mon_clear();
        phase(0, 10);
        pwm = 1'b1;
        tick(LAT);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        chk("t6_valid16", if16.valid, 0);
        phase(1, 8); phase(0, 8); phase(1, 8); phase(0, 8); phase(1, 8); phase(0, 8);
        chk("t6_nvalid16", nv[0], 1);
        chk("t6_first_high16", fh[0], 8);
        chk("t6_first_period16", fp[0], 16);

        // Randomized waveform, READY and rare CLR, checked by the model
        do_clr();
        repeat (300) begin
            hi = ($urandom_range(0, 29) == 0) ? int'($urandom_range(200, 300))
                                              : int'($urandom_range(1, 20));
            lo = int'($urandom_range(1, 20));
            for (int c = 0; c < hi + lo; c++) begin
                pwm = (c < hi);
                rdy = ($urandom_range(0, 3) != 0);
                clr = ($urandom_range(0, 499) == 0);
                tick(1);
            end
        end
        clr = 1'b0;
        rdy = 1'b1;
        phase(0, 20);

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
